// File: rtl/image_sample_fetcher.sv
// rtl/image_sample_fetcher.sv - image RAM read sequencer presenting image/label samples over a valid/ready stream
// Optional FETCH_SHUFFLE_EN: LFSR-driven address order instead of sequential.
module image_sample_fetcher #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 794,
    parameter int DEPTH       = 60000,
    parameter int LABEL_WIDTH = 10,
    parameter int NUM_EPOCHS  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              ram_en,
    output logic                              ram_we,
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    input  logic [DATA_WIDTH-1:0]             ram_dout,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-LABEL_WIDTH-1:0] m_image,
    output logic [LABEL_WIDTH-1:0]            m_label,
    output logic [3:0]                        m_class,
    output logic [ADDR_WIDTH-1:0]             m_index,
    output logic [7:0]                        epoch,
    output logic                              busy,
    output logic                              done,
    output logic                              label_err,
    output logic [15:0]                       err_count
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, DONE} state_t;

    state_t                  state;
    logic [31:0]             sample_cnt;
    logic [LABEL_WIDTH-1:0]  cap_label;
    logic                    cnt_last;
    logic                    last_epoch;
    logic                    fetch_now;
    logic                    fetch_en;
    logic [ADDR_WIDTH-1:0]   fetch_addr;

    function automatic logic [3:0] class_of(input logic [LABEL_WIDTH-1:0] l);
        class_of = '0;
        for (int i = LABEL_WIDTH - 1; i >= 0; i--) begin
            if (l[i]) class_of = 4'(i);
        end
    endfunction

    assign ram_we     = 1'b0;
    assign cap_label  = ram_dout[LABEL_WIDTH-1:0];
    assign cnt_last   = (sample_cnt + 32'd1 == 32'(DEPTH));
    assign last_epoch = ({24'd0, epoch} + 32'd1 == 32'(NUM_EPOCHS));

    // A new address is fetched on start, on every non-final accept, and on each ISSUE cycle still searching.
    always_comb begin
        fetch_now = 1'b0;
        if ((state == IDLE || state == DONE) && start)
            fetch_now = 1'b1;
        else if (state == ISSUE && !ram_en)
            fetch_now = 1'b1;
        else if (state == PRESENT && m_ready && !(cnt_last && last_epoch))
            fetch_now = 1'b1;
    end

`ifdef FETCH_SHUFFLE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] cand;

    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
    assign cand       = lfsr - 16'd1;
    assign fetch_en   = (32'(cand) < 32'(DEPTH));
    assign fetch_addr = ADDR_WIDTH'(cand);

    // Each LFSR state is consumed exactly once, whether its candidate is used or skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 16'h0001;
        else if (fetch_now)
            lfsr <= lfsr_next;
    end

    if (ADDR_WIDTH != 16) begin : g_addr_width_check
        $error("image_sample_fetcher: shuffle mode needs ADDR_WIDTH == 16");
    end
`else
    assign fetch_en   = 1'b1;
    assign fetch_addr = (state == PRESENT && !cnt_last) ? ram_addr + ADDR_WIDTH'(1) : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            m_valid    <= 1'b0;
            m_image    <= '0;
            m_label    <= '0;
            m_class    <= '0;
            m_index    <= '0;
            epoch      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            label_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        epoch      <= '0;
                        sample_cnt <= '0;
                        label_err  <= 1'b0;
                        err_count  <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ram_en) begin
                        ram_en <= 1'b0;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    m_image <= ram_dout[DATA_WIDTH-1:LABEL_WIDTH];
                    m_label <= cap_label;
                    m_class <= class_of(cap_label);
                    m_index <= ram_addr;
                    if ($countones(cap_label) != 1) begin
                        label_err <= 1'b1;
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    end
                    m_valid <= 1'b1;
                    state   <= PRESENT;
                end
                PRESENT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (cnt_last) begin
                            sample_cnt <= '0;
                            epoch      <= epoch + 8'd1;
                        end else begin
                            sample_cnt <= sample_cnt + 32'd1;
                        end
                        if (cnt_last && last_epoch) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (fetch_now) begin
                ram_en <= fetch_en;
                if (fetch_en) ram_addr <= fetch_addr;
            end
        end
    end

endmodule

// File: doc/image_sample_fetcher.md
# image_sample_fetcher

Read-side sequencer for the single-port training image RAM. It walks the RAM address space for a programmable number of epochs and splits each row into a 784-bit image and a 10-bit label. Each sample is presented to the learning datapath over a valid/ready stream. The block sits between the image RAM and the Boolean-circuit trainer, and it is the only agent driving the RAM during training.

## Interface
Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 794, RAM row width.
- DEPTH, 60000, number of valid rows (addresses 0..DEPTH-1).
- LABEL_WIDTH, 10, label field width (one-hot class).
- NUM_EPOCHS, 1, number of full passes per start.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- ram_en  out  ADDR_WIDTH-independent 1  RAM enable.
- ram_we  out  1  constant 0.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_dout  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en.
- m_valid  out  1  sample available.
- m_ready  in  1  downstream accepts.
- m_image  out  DATA_WIDTH-LABEL_WIDTH  row bits [DATA_WIDTH-1:LABEL_WIDTH].
- m_label  out  LABEL_WIDTH  row bits [LABEL_WIDTH-1:0].
- m_class  out  4  index of the lowest set bit of m_label; 0 if the label is all zero.
- m_index  out  ADDR_WIDTH  RAM address of the presented sample.
- epoch  out  8  current epoch, 0-based.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- label_err  out  1  sticky; set on any non-one-hot label.
- err_count  out  16  saturating count of non-one-hot labels.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE/DONE + start:
  - Clear epoch, the sample counter, label_err and err_count.
  - Load the first address.
  - Go to ISSUE.
- ISSUE:
  - ram_en=1 with ram_addr equal to the current address.
  - Go to CAPTURE.
- CAPTURE:
  - Register ram_dout into the output fields, and m_index from the address.
  - Compute the one-hot check and m_class from the captured label.
  - Go to PRESENT.
- PRESENT:
  - m_valid=1 and all outputs held stable until m_ready=1.
  - On accept, increment the sample counter.
  - If the counter reaches DEPTH, clear it and increment epoch; if epoch+1 == NUM_EPOCHS, go to DONE.
  - Otherwise, advance the address and go to ISSUE.
- Sequential address order: 0,1,…,DEPTH-1, then wrap to 0 at each epoch boundary.
- Label check: popcount(label) != 1 sets label_err and increments err_count, saturating at 16'hFFFF. The sample is still delivered.
- start is ignored while busy.
- m_ready is ignored outside PRESENT.
- ram_en is 0 in every state except ISSUE.

## Timing
- Reset values: state IDLE; ram_en, m_valid, busy, done and label_err all 0; ram_addr, m_image, m_label, m_class, m_index, epoch and err_count all 0. ram_we is always 0.
- start sampled high at edge 0 gives:
  - ram_en high in cycle 1;
  - data captured at edge 2;
  - m_valid high from cycle 3.
- With m_ready held high, throughput is 1 sample per 3 cycles (PRESENT → ISSUE → CAPTURE → PRESENT).
- m_valid deasserts the cycle after accept. It never drops without an accept, except on reset.
- Final accept: done=1 and busy=0 on the next cycle. Outputs hold their last sample with m_valid=0.
- Reset mid-run aborts immediately:
  - all outputs return to their reset values;
  - no further RAM access occurs;
  - the partially fetched sample is discarded.

## Configuration
- FETCH_SHUFFLE_EN, when defined:
  - Addresses come from a 16-bit Fibonacci LFSR, polynomial x^16+x^15+x^13+x^4+1, seeded to 16'h0001 by reset.
  - The candidate address is lfsr-1. The LFSR steps once per cycle in ISSUE until the candidate is < DEPTH; ram_en asserts only on the cycle a valid candidate is presented, so ISSUE may last several cycles.
  - The LFSR is not reseeded by start or at epoch boundaries. Because it has a full 65535-state period, every epoch visits each address 0..DEPTH-1 exactly once.
  - ADDR_WIDTH must be 16; elaboration fails otherwise.
- Without FETCH_SHUFFLE_EN: sequential order only, with no LFSR logic.

## Test plan
- Basic sequential sweep:
  - Setup: DEPTH=4, NUM_EPOCHS=2, m_ready=1, rows with one-hot labels, start pulse.
  - Required: m_index sequence 0,1,2,3,0,1,2,3; epoch goes 0 → 1 after the 4th accept; done=1 after the 8th accept; 3 cycles per sample.
- Backpressure:
  - Setup: hold m_ready=0 for 10 cycles in PRESENT.
  - Required: m_valid stays 1; m_image, m_label and m_index stay constant; ram_en stays 0; exactly one accept occurs when m_ready rises.
- Label errors:
  - Setup: rows with labels 10'b0 and 10'b0000000110 among valid ones.
  - Required: both rows are delivered; label_err=1; err_count=2; m_class=0 for the zero label and m_class=1 for 10'b0000000110.
- Reset mid-run:
  - Setup: assert rst while in CAPTURE.
  - Required: all outputs are at reset values in the same cycle; a following start restarts at m_index 0 and epoch 0.
- start while busy:
  - Setup: pulse start during PRESENT.
  - Required: no effect on the sequence or the counters.
- Shuffle (FETCH_SHUFFLE_EN, DEPTH=60000, NUM_EPOCHS=2):
  - Required: each epoch emits 60000 distinct m_index values, all < 60000.
  - Required: the first address is 0, since the seed is 1 and the candidate is lfsr-1.
